// File: rtl/control_fsm_param_if.sv
// Control-unit bus: done strobes and instruction in, datapath controls out.
// The control unit takes the master side.
interface control_fsm_param_if #(
  parameter int PCW = 13,
  parameter int RAW = 3,
  parameter int OPW = 3
);
  localparam int IW = OPW + 1 + 3 * RAW;

  logic [1:0]       DoneRegFlag;
  logic             DoneALU;
  logic             DoneImmediate;
  logic [IW-1:0]    Instruction;
  logic [PCW-1:0]   PC;
  logic [3*RAW-1:0] RegSelect;
  logic             InstructionTypeSelect;
  logic [OPW-1:0]   Opcode;
  logic             WriteFlag;
  logic             Halted;
  logic             Timeout;
  logic [2:0]       StateOut;

  modport master (
    input  DoneRegFlag, DoneALU, DoneImmediate, Instruction,
    output PC, RegSelect, InstructionTypeSelect, Opcode,
    output WriteFlag, Halted, Timeout, StateOut
  );

  modport slave (
    output DoneRegFlag, DoneALU, DoneImmediate, Instruction,
    input  PC, RegSelect, InstructionTypeSelect, Opcode,
    input  WriteFlag, Halted, Timeout, StateOut
  );
endinterface

// File: rtl/control_fsm_param.sv
// Multicycle control unit: fetch/decode/regread/imm/exec/writeback,
// with halt opcode and a per-wait-state watchdog.
module control_fsm_param #(
  parameter int PCW            = 13,
  parameter int RAW            = 3,
  parameter int OPW            = 3,
  parameter int HALT_OP        = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  control_fsm_param_if.master bus
);

  localparam int IW  = OPW + 1 + 3 * RAW;
  localparam int WDW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WDW-1:0] WD_LAST =
    WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_REG_RD = 3'd2,
    S_IMM    = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           wf_q, wf_d;
  logic           halt_q, halt_d;
  logic           to_q, to_d;

  logic   waiting;
  logic   wait_done;
  state_e nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      wd_q    <= '0;
      wf_q    <= 1'b0;
      halt_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wd_q    <= wd_d;
      wf_q    <= wf_d;
      halt_q  <= halt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wd_d      = '0;
    wf_d      = wf_q;
    halt_d    = halt_q;
    to_d      = to_q;
    waiting   = 1'b0;
    wait_done = 1'b0;
    nxt       = state_q;

    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = bus.Instruction;
        if (bus.Instruction[IW-1-:OPW] == OPW'(HALT_OP)) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end else begin
          state_d = S_REG_RD;
        end
      end
      S_REG_RD: begin
        waiting   = 1'b1;
        wait_done = bus.DoneRegFlag[0];
        nxt       = ir_q[3*RAW] ? S_IMM : S_EXEC;
      end
      S_IMM: begin
        waiting   = 1'b1;
        wait_done = bus.DoneImmediate;
        nxt       = S_EXEC;
      end
      S_EXEC: begin
        waiting   = 1'b1;
        wait_done = bus.DoneALU;
        nxt       = S_WB;
      end
      S_WB: begin
        waiting   = 1'b1;
        wait_done = bus.DoneRegFlag[1];
        nxt       = S_FETCH;
      end
      S_HALT: wf_d = 1'b0;
      default: state_d = S_FETCH;
    endcase

    // A done seen on the last watchdog cycle still wins over timeout.
    if (waiting) begin
      if (wait_done) begin
        state_d = nxt;
        if (state_q == S_EXEC) wf_d = 1'b1;
        if (state_q == S_WB) begin
          wf_d = 1'b0;
          pc_d = pc_q + PCW'(1);
        end
      end else if (WD_EN && wd_q == WD_LAST) begin
        state_d = S_HALT;
        halt_d  = 1'b1;
        to_d    = 1'b1;
        wf_d    = 1'b0;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end
  end

  assign bus.PC                    = pc_q;
  assign bus.RegSelect             = ir_q[3*RAW-1:0];
  assign bus.InstructionTypeSelect = ir_q[3*RAW];
  assign bus.Opcode                = ir_q[IW-1-:OPW];
  assign bus.WriteFlag             = wf_q;
  assign bus.Halted                = halt_q;
  assign bus.Timeout               = to_q;
  assign bus.StateOut              = state_q;

endmodule

// File: tb/tb_control_fsm_param.sv
// Bench for control_fsm_param: per-instruction scoreboard fed at
// decode, drained on writeback/halt; done responder with delay tables.
module tb_control_fsm_param;

  localparam int PCW = 4;
  localparam int RAW = 3;
  localparam int OPW = 3;
  localparam int TO  = 8;
  localparam int IW  = 13;
  localparam int NPC = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  control_fsm_param_if #(.PCW(PCW), .RAW(RAW), .OPW(OPW)) bus();

  control_fsm_param #(
    .PCW(PCW), .RAW(RAW), .OPW(OPW),
    .HALT_OP(7), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [IW-1:0] imem [NPC];
  int dly_rd [NPC];
  int dly_imm[NPC];
  int dly_alu[NPC];
  int dly_wb [NPC];

  assign bus.Instruction = imem[bus.PC];

  typedef struct {
    int pc; int op; int rs; int typ;
    int hlt; int to; int lat; int wf;
  } exp_t;

  exp_t sbq[$];
  int model_pc, pops;
  int n_chk, n_err;
  int lat_cnt, wf_cnt, prev, cnt, st;
  int c_rd, c_imm, c_alu, c_wb;
  bit noise;

  task automatic chk(string tag, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_push();
    exp_t e;
    int d[4];
    logic [IW-1:0] ins;
    ins   = imem[model_pc];
    e.op  = int'(ins[12:10]);
    e.typ = int'(ins[9]);
    e.rs  = int'(ins[8:0]);
    e.hlt = int'(e.op == 7);
    e.to  = 0;
    e.lat = 1;
    e.wf  = 0;
    c_rd  = dly_rd[model_pc];
    c_imm = dly_imm[model_pc];
    c_alu = dly_alu[model_pc];
    c_wb  = dly_wb[model_pc];
    if (e.hlt == 0) begin
      d = '{c_rd, (e.typ != 0) ? c_imm : -1, c_alu, c_wb};
      for (int i = 0; i < 4; i++) begin
        if (d[i] >= 0 && e.to == 0) begin
          if (d[i] >= TO) begin
            e.lat += TO;
            e.to = 1;
            if (i == 3) e.wf = TO;
          end else begin
            e.lat += d[i] + 1;
            if (i == 3) e.wf = d[i] + 1;
          end
        end
      end
    end
    e.pc = (e.hlt != 0 || e.to != 0) ? model_pc
                                     : (model_pc + 1) % NPC;
    chk("pc_at_decode", int'(bus.PC), model_pc);
    sbq.push_back(e);
    lat_cnt = 0;
    wf_cnt  = 0;
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk("pc", int'(bus.PC), e.pc);
    chk("opcode", int'(bus.Opcode), e.op);
    chk("regsel", int'(bus.RegSelect), e.rs);
    chk("itype", int'(bus.InstructionTypeSelect), e.typ);
    chk("halted", int'(bus.Halted), int'(e.hlt != 0 || e.to != 0));
    chk("timeout", int'(bus.Timeout), e.to);
    chk("latency", lat_cnt, e.lat);
    chk("wf_cycles", wf_cnt, e.wf);
    model_pc = e.pc;
    pops++;
  endtask

  // Monitor and done responder share one negedge process.
  always @(negedge clk) begin
    if (!reset) begin
      prev = 0;
      cnt  = 0;
      bus.DoneRegFlag   = 2'b00;
      bus.DoneImmediate = 1'b0;
      bus.DoneALU       = 1'b0;
    end else begin
      st = int'(bus.StateOut);
      lat_cnt++;
      wf_cnt += int'(bus.WriteFlag);
      if (st == 1 && prev != 1) sb_push();
      if ((st == 0 && prev == 5) || (st == 6 && prev != 6)) sb_pop();
      cnt  = (st == prev) ? cnt + 1 : 0;
      prev = st;
      bus.DoneRegFlag[0] = (st == 2 && cnt >= c_rd)  || (noise && st != 2);
      bus.DoneRegFlag[1] = (st == 5 && cnt >= c_wb)  || (noise && st != 5);
      bus.DoneImmediate  = (st == 3 && cnt >= c_imm) || (noise && st != 3);
      bus.DoneALU        = (st == 4 && cnt >= c_alu) || (noise && st != 4);
    end
  end

  task automatic clear_tables();
    for (int i = 0; i < NPC; i++) begin
      dly_rd[i]  = 0;
      dly_imm[i] = 0;
      dly_alu[i] = 0;
      dly_wb[i]  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    sbq.delete();
    model_pc = 0;
    pops = 0;
    #1;
    chk("rst_pc", int'(bus.PC), 0);
    chk("rst_state", int'(bus.StateOut), 0);
    chk("rst_wf", int'(bus.WriteFlag), 0);
    chk("rst_halted", int'(bus.Halted), 0);
    chk("rst_timeout", int'(bus.Timeout), 0);
    chk("rst_regsel", int'(bus.RegSelect), 0);
    chk("rst_opcode", int'(bus.Opcode), 0);
    chk("rst_itype", int'(bus.InstructionTypeSelect), 0);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic wait_pops(string tag, int target);
    int n = 0;
    while (pops < target && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, pops, target);
  endtask

  int s1_trace[5] = '{1, 2, 4, 5, 0};
  int n;

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < NPC; i++) imem[i] = '0;
    clear_tables();

    // R-type, I-type with late immediate, done on last watchdog cycle,
    // then a never-ready ALU that trips the watchdog.
    imem[0]    = 13'h001A;
    imem[1]    = {3'd3, 1'b1, 3'd1, 3'd2, 3'd3};
    imem[2]    = {3'd5, 1'b0, 3'd4, 3'd5, 3'd6};
    imem[3]    = {3'd2, 1'b0, 3'd7, 3'd0, 3'd1};
    dly_imm[1] = 3;
    dly_alu[2] = TO - 1;
    dly_alu[3] = 100;
    noise = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("s1_state", int'(bus.StateOut), s1_trace[i]);
    end
    chk("s1_pc", int'(bus.PC), 1);
    wait_pops("runA_done", 4);
    repeat (3) @(negedge clk);
    #1;
    chk("to_state", int'(bus.StateOut), 6);
    chk("to_halted", int'(bus.Halted), 1);
    chk("to_flag", int'(bus.Timeout), 1);
    chk("to_wf", int'(bus.WriteFlag), 0);
    chk("to_pc", int'(bus.PC), 3);

    // Halt opcode: terminal, ignores dones and instruction changes.
    clear_tables();
    imem[0] = {3'd7, 1'b0, 9'h0AB};
    do_reset();
    wait_pops("halt_done", 1);
    repeat (10) @(negedge clk);
    imem[0] = 13'h001A;
    repeat (10) @(negedge clk);
    #1;
    chk("halt_state", int'(bus.StateOut), 6);
    chk("halt_pc", int'(bus.PC), 0);
    chk("halt_halted", int'(bus.Halted), 1);
    chk("halt_timeout", int'(bus.Timeout), 0);
    chk("halt_wf", int'(bus.WriteFlag), 0);
    chk("halt_opcode", int'(bus.Opcode), 7);

    // Sixteen random instructions: PC wraps 15 -> 0.
    noise = 1'b0;
    for (int i = 0; i < NPC; i++) begin
      imem[i] = {3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                 9'($urandom_range(0, 511))};
      dly_rd[i]  = $urandom_range(0, 3);
      dly_imm[i] = $urandom_range(0, 3);
      dly_alu[i] = $urandom_range(0, 3);
      dly_wb[i]  = $urandom_range(0, 3);
    end
    dly_wb[9] = TO - 1;
    do_reset();
    wait_pops("wrap_done", NPC);
    chk("wrap_pc", int'(bus.PC), 0);
    chk("wrap_timeout", int'(bus.Timeout), 0);

    // Reset asserted in the middle of a writeback.
    clear_tables();
    dly_wb[1] = 4;
    do_reset();
    wait_pops("wb_first", 1);
    n = 0;
    while (int'(bus.StateOut) != 5 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wb_state", int'(bus.StateOut), 5);
    chk("wb_wf", int'(bus.WriteFlag), 1);
    chk("wb_pc", int'(bus.PC), 1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_wf", int'(bus.WriteFlag), 0);
    chk("midrst_pc", int'(bus.PC), 0);
    chk("midrst_state", int'(bus.StateOut), 0);
    chk("midrst_halted", int'(bus.Halted), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
